// File: rtl/rgb_fade_sequencer.sv
// -----------------------------------------------------------------------------
// rgb_fade_sequencer
//
// Purpose:
//   Drives the 8-bit R/G/B duty-cycle inputs of the RGB PWM controller from a
//   small writable colour palette. Each channel ramps by +/-1 per step tick
//   toward the current palette entry. Once all three channels match, the colour
//   is held for HOLD_CYCLES. The sequencer then advances to the next entry and
//   wraps from the last entry back to entry 0.
//
// Ports:
//   clk_in      system clock
//   rst_in      asynchronous, active-high reset
//   start_in    1-cycle pulse, starts the sequence at palette[0] (IDLE only)
//   stop_in     1-cycle pulse, returns to IDLE and freezes the colour outputs
//   wr_en_in    palette write strobe
//   wr_addr_in  palette write address (out-of-range addresses are dropped)
//   wr_data_in  palette word {R[23:16], G[15:8], B[7:0]}
//   r_out       red duty cycle
//   g_out       green duty cycle
//   b_out       blue duty cycle
//   idx_out     palette index currently targeted
//   busy_out    1 while fading or holding
//
// States:
//   state | meaning
//   IDLE  | outputs frozen, waiting for start_in
//   FADE  | ramping each channel one step per tick toward tgt
//   HOLD  | target reached, dwelling HOLD_CYCLES before the next entry
// -----------------------------------------------------------------------------
module rgb_fade_sequencer #(
  parameter int NUM_COLORS  = 4,
  parameter int STEP_CYCLES = 1000,
  parameter int HOLD_CYCLES = 50000
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic                          stop_in,
  input  logic                          wr_en_in,
  input  logic [$clog2(NUM_COLORS)-1:0] wr_addr_in,
  input  logic [23:0]                   wr_data_in,
  output logic [7:0]                    r_out,
  output logic [7:0]                    g_out,
  output logic [7:0]                    b_out,
  output logic [$clog2(NUM_COLORS)-1:0] idx_out,
  output logic                          busy_out
);

  localparam int IW = $clog2(NUM_COLORS);
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_COLORS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [23:0]    tgt_q, tgt_d;
  logic [SW-1:0]  step_q, step_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [7:0]     r_q, r_d;
  logic [7:0]     g_q, g_d;
  logic [7:0]     b_q, b_d;
  logic           busy_q, busy_d;
  logic [23:0]    palette_q [NUM_COLORS];

  logic           at_tgt;
  logic [IW-1:0]  idx_next;

  // One step toward the target. Saturation is implicit: a channel only moves
  // when it differs from the target, so it can never pass 0 or 255.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt);
    if (cur < tgt) begin
      return cur + 8'd1;
    end else if (cur > tgt) begin
      return cur - 8'd1;
    end else begin
      return cur;
    end
  endfunction

  assign at_tgt   = ({r_q, g_q, b_q} == tgt_q);
  assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  // Palette: writes are allowed in every state. The active colour lives in
  // tgt_q, so rewriting the active entry only matters on its next visit.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_COLORS; i++) begin
        palette_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_COLORS; i++) begin
        if (wr_en_in && (wr_addr_in == IW'(i))) begin
          palette_q[i] <= wr_data_in;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    hold_d  = hold_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;

    // stop wins over everything, including a coincident start or step tick;
    // the colour and index registers simply keep their values.
    if (stop_in) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_in) begin
            state_d = FADE;
            idx_d   = '0;
            tgt_d   = palette_q[0];
            step_d  = '0;
          end
        end

        FADE: begin
          if (at_tgt) begin
            state_d = HOLD;
            hold_d  = '0;
          end else if (step_q == STEP_LAST) begin
            step_d = '0;
            r_d    = step_toward(r_q, tgt_q[23:16]);
            g_d    = step_toward(g_q, tgt_q[15:8]);
            b_d    = step_toward(b_q, tgt_q[7:0]);
          end else begin
            step_d = step_q + 1'b1;
          end
        end

        HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = FADE;
            idx_d   = idx_next;
            tgt_d   = palette_q[idx_next];
            step_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign r_out    = r_q;
  assign g_out    = g_q;
  assign b_out    = b_q;
  assign idx_out  = idx_q;
  assign busy_out = busy_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench: the stimulus thread pushes every expected output change
// (cycle number plus {r,g,b,idx,busy}) into a queue; the monitor pops an entry
// each time the sampled outputs change and compares value and cycle.
module tb_rgb_fade_sequencer;

  localparam int NC = 4;
  localparam int SC = 4;
  localparam int HC = 10;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        stop_in;
  logic        wr_en_in;
  logic [1:0]  wr_addr_in;
  logic [23:0] wr_data_in;
  logic [7:0]  r_out, g_out, b_out;
  logic [1:0]  idx_out;
  logic        busy_out;

  rgb_fade_sequencer #(
    .NUM_COLORS (NC),
    .STEP_CYCLES(SC),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start_in  (start_in),
    .stop_in   (stop_in),
    .wr_en_in  (wr_en_in),
    .wr_addr_in(wr_addr_in),
    .wr_data_in(wr_data_in),
    .r_out     (r_out),
    .g_out     (g_out),
    .b_out     (b_out),
    .idx_out   (idx_out),
    .busy_out  (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Edge counter: after posedge number n, the following negedge sees cyc == n.
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct packed {
    int          c;
    logic [26:0] v;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  logic [26:0] prev;

  function automatic logic [26:0] snap();
    return {r_out, g_out, b_out, idx_out, busy_out};
  endfunction

  task automatic expect_chg(input int c, input logic [23:0] rgb,
                            input logic [1:0] idx, input logic busy);
    exp_t e;
    e.c = c;
    e.v = {rgb, idx, busy};
    sb_q.push_back(e);
  endtask

  // Monitor: one comparison per observed output change.
  always @(negedge clk_in) begin
    if (mon_en) begin
      logic [26:0] s;
      exp_t e;
      s = snap();
      if (s !== prev) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: cyc=%0d got=%h required=no change", cyc, s);
        end else begin
          e = sb_q.pop_front();
          if (s !== e.v || cyc != e.c) begin
            bad++;
            $display("FAIL chg: got=%h at cyc %0d, required=%h at cyc %0d",
                     s, cyc, e.v, e.c);
          end
        end
        prev = s;
      end
    end
  end

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk_in);
  endtask

  task automatic issue(input logic st, input logic sp, output int edge_n);
    @(negedge clk_in);
    start_in = st;
    stop_in  = sp;
    edge_n   = cyc + 1;
  endtask

  task automatic release_ctl();
    @(negedge clk_in);
    start_in = 1'b0;
    stop_in  = 1'b0;
  endtask

  task automatic pal_write(input logic [1:0] a, input logic [23:0] d);
    @(negedge clk_in);
    wr_en_in   = 1'b1;
    wr_addr_in = a;
    wr_data_in = d;
    @(negedge clk_in);
    wr_en_in   = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h required=%h", name, got, want);
    end
  endtask

  int s, p, f0, f1, f2, f3, f4, f5, f6, dummy;

  initial begin
    rst_in = 1'b0; start_in = 1'b0; stop_in = 1'b0;
    wr_en_in = 1'b0; wr_addr_in = '0; wr_data_in = '0;

    // Reset asserted between edges must clear outputs immediately.
    repeat (2) @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("rst_r",    32'(r_out),    32'h0);
    check("rst_g",    32'(g_out),    32'h0);
    check("rst_b",    32'(b_out),    32'h0);
    check("rst_idx",  32'(idx_out),  32'h0);
    check("rst_busy", 32'(busy_out), 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("post_rst_busy", 32'(busy_out), 32'h0);
    check("post_rst_rgb",  32'({r_out, g_out, b_out}), 32'h0);
    prev   = snap();
    mon_en = 1'b1;

    pal_write(2'd0, 24'h030000);
    pal_write(2'd1, 24'h000002);
    pal_write(2'd2, 24'h000102);
    pal_write(2'd3, 24'h010000);

    // First run: ramp red, stop mid-FADE at r=2.
    issue(1'b1, 1'b0, s);
    expect_chg(s,     24'h000000, 2'd0, 1'b1);
    expect_chg(s + 4, 24'h010000, 2'd0, 1'b1);
    expect_chg(s + 8, 24'h020000, 2'd0, 1'b1);
    release_ctl();
    wait_until(s + 9);
    issue(1'b0, 1'b1, p);
    expect_chg(p, 24'h020000, 2'd0, 1'b0);
    release_ctl();

    // start and stop together: must stay IDLE with nothing changing.
    wait_until(s + 25);
    issue(1'b1, 1'b1, dummy);
    release_ctl();
    repeat (3) @(negedge clk_in);
    check("start_stop_busy", 32'(busy_out), 32'h0);

    // Restart from the frozen colour and run the whole palette with wrap.
    issue(1'b1, 1'b0, f0);
    f1 = f0 + 15;
    f2 = f1 + 23;
    f3 = f2 + 15;
    f4 = f3 + 19;
    f5 = f4 + 19;
    f6 = f5 + 23;
    expect_chg(f0,      24'h020000, 2'd0, 1'b1);
    expect_chg(f0 + 4,  24'h030000, 2'd0, 1'b1);
    expect_chg(f1,      24'h030000, 2'd1, 1'b1);
    expect_chg(f1 + 4,  24'h020001, 2'd1, 1'b1);
    expect_chg(f1 + 8,  24'h010002, 2'd1, 1'b1);
    expect_chg(f1 + 12, 24'h000002, 2'd1, 1'b1);
    expect_chg(f2,      24'h000002, 2'd2, 1'b1);
    expect_chg(f2 + 4,  24'h000102, 2'd2, 1'b1);
    expect_chg(f3,      24'h000102, 2'd3, 1'b1);
    expect_chg(f3 + 4,  24'h010001, 2'd3, 1'b1);
    expect_chg(f3 + 8,  24'h010000, 2'd3, 1'b1);
    expect_chg(f4,      24'h010000, 2'd0, 1'b1);
    expect_chg(f4 + 4,  24'h020000, 2'd0, 1'b1);
    expect_chg(f4 + 8,  24'h030000, 2'd0, 1'b1);
    expect_chg(f5,      24'h030000, 2'd1, 1'b1);
    expect_chg(f5 + 4,  24'h020001, 2'd1, 1'b1);
    expect_chg(f5 + 8,  24'h010002, 2'd1, 1'b1);
    expect_chg(f5 + 12, 24'h000003, 2'd1, 1'b1);
    expect_chg(f6,      24'h000003, 2'd2, 1'b1);
    expect_chg(f6 + 4,  24'h000102, 2'd2, 1'b1);
    release_ctl();

    // Rewrite the active entry mid-FADE: old target this visit, new one next.
    wait_until(f1 + 1);
    pal_write(2'd1, 24'h000003);

    // start during FADE is ignored.
    wait_until(f2 + 1);
    issue(1'b1, 1'b0, dummy);
    release_ctl();

    // Stop during HOLD: colour and index freeze, busy drops.
    wait_until(f6 + 7);
    issue(1'b0, 1'b1, p);
    expect_chg(p, 24'h000102, 2'd2, 1'b0);
    release_ctl();

    wait_until(p + 30);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL missing_changes: got=%0d pending required=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
